// File: rtl/tq_chroma_dc_seq.sv
// tq_chroma_dc_seq: sequences 4 Cb + 4 Cr chroma DC levels through the shared inverse Hadamard/dequant datapath
module tq_chroma_dc_ih_iqt #(
  parameter int DW  = 15,
  parameter int QPW = 6
) (
  input  logic [3:0][DW-1:0] coef,
  input  logic [QPW-1:0]     qp,
  output logic [3:0][DW-1:0] dc
);
  localparam int PW = DW + 26;
  logic [QPW-1:0] qp_div, qp_mod;
  logic signed [5:0] v;
  logic signed [DW+1:0] e [4];
  logic signed [DW+1:0] f [4];
  assign qp_div = qp / QPW'(6);
  assign qp_mod = qp % QPW'(6);
  assign v = qp_mod == QPW'(0) ? 6'sd10 :
             qp_mod == QPW'(1) ? 6'sd11 :
             qp_mod == QPW'(2) ? 6'sd13 :
             qp_mod == QPW'(3) ? 6'sd14 :
             qp_mod == QPW'(4) ? 6'sd16 : 6'sd18;
  for (genvar k = 0; k < 4; k++) begin : g_ext
    assign e[k] = (DW+2)'($signed(coef[k]));
  end
  assign f[0] = e[0] + e[1] + e[2] + e[3];
  assign f[1] = e[0] - e[1] + e[2] - e[3];
  assign f[2] = e[0] + e[1] - e[2] - e[3];
  assign f[3] = e[0] - e[1] - e[2] + e[3];
  // LevelScale*16 >> 5 folds to v >> 1 with flat weights
  for (genvar k = 0; k < 4; k++) begin : g_scale
    logic signed [PW-1:0] p;
    assign p = (PW'(f[k]) * PW'(v)) <<< qp_div;
    assign dc[k] = DW'(p >>> 1);
  end
endmodule

module tq_chroma_dc_seq #(
  parameter int DW  = 15,
  parameter int QPW = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start_i,
  input  logic [QPW-1:0] qp_cb_i,
  input  logic [QPW-1:0] qp_cr_i,
  input  logic           coeff_valid_i,
  output logic           coeff_ready_o,
  input  logic [DW-1:0]  coeff_i,
  output logic           dc_valid_o,
  input  logic           dc_ready_i,
  output logic           dc_comp_o,
  output logic [DW-1:0]  dc00_o,
  output logic [DW-1:0]  dc01_o,
  output logic [DW-1:0]  dc10_o,
  output logic [DW-1:0]  dc11_o,
  output logic           busy_o,
  output logic           done_o
);
  typedef enum logic [1:0] {IDLE, LOAD, CALC, OUT} state_t;
  state_t state, state_nxt;
  logic [1:0] cnt;
  logic comp, accept, hs, go;
  logic [QPW-1:0] qp_cb_q, qp_cr_q;
  logic [3:0][DW-1:0] coef_q, dp_dc, dc_q;
  tq_chroma_dc_ih_iqt #(.DW(DW), .QPW(QPW)) u_dp (
    .coef(coef_q),
    .qp  (comp ? qp_cr_q : qp_cb_q),
    .dc  (dp_dc)
  );
  always_comb begin
    go = state == IDLE && start_i;
    accept = state == LOAD && coeff_valid_i;
    hs = state == OUT && dc_valid_o && dc_ready_i;
    state_nxt = go ? LOAD :
                (accept && cnt == 2'd3) ? CALC :
                state == CALC ? OUT :
                hs ? (comp ? IDLE : LOAD) : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      comp <= 1'b0;
      qp_cb_q <= '0;
      qp_cr_q <= '0;
      coef_q <= '0;
      dc_q <= '0;
      dc_comp_o <= 1'b0;
      dc_valid_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      state <= state_nxt;
      done_o <= hs && comp;
      if (go) begin
        qp_cb_q <= qp_cb_i;
        qp_cr_q <= qp_cr_i;
        comp <= 1'b0;
        cnt <= '0;
      end
      if (accept) begin
        coef_q[cnt] <= coeff_i;
        cnt <= cnt + 2'd1;
      end
      if (state == CALC) begin
        dc_q <= dp_dc;
        dc_comp_o <= comp;
        dc_valid_o <= 1'b1;
      end
      if (hs) begin
        dc_valid_o <= 1'b0;
        comp <= 1'b1;
      end
    end
  end
  assign coeff_ready_o = state == LOAD;
  assign busy_o = state != IDLE;
  assign dc00_o = dc_q[0];
  assign dc01_o = dc_q[1];
  assign dc10_o = dc_q[2];
  assign dc11_o = dc_q[3];
endmodule

// File: tb/tb_tq_chroma_dc_seq.sv
// tb_tq_chroma_dc_seq: scoreboard bench for the chroma DC sequencer against an arithmetic model
module tb_tq_chroma_dc_seq;
  typedef logic signed [14:0] co_t;
  typedef struct packed {logic comp; logic [3:0][14:0] d;} grp_t;
  logic clk = 0, rst = 1, start_i = 0, coeff_valid_i = 0, dc_ready_i = 0;
  logic [5:0] qp_cb_i = 0, qp_cr_i = 0;
  logic [14:0] coeff_i = 0;
  logic coeff_ready_o, dc_valid_o, dc_comp_o, busy_o, done_o;
  logic [14:0] dc00_o, dc01_o, dc10_o, dc11_o;
  int n_chk = 0, n_pass = 0, rdy_mode = 0, hold = 0;
  grp_t sb[$];
  tq_chroma_dc_seq dut (
    .clk(clk), .rst(rst), .start_i(start_i), .qp_cb_i(qp_cb_i), .qp_cr_i(qp_cr_i),
    .coeff_valid_i(coeff_valid_i), .coeff_ready_o(coeff_ready_o), .coeff_i(coeff_i),
    .dc_valid_o(dc_valid_o), .dc_ready_i(dc_ready_i), .dc_comp_o(dc_comp_o),
    .dc00_o(dc00_o), .dc01_o(dc01_o), .dc10_o(dc10_o), .dc11_o(dc11_o),
    .busy_o(busy_o), .done_o(done_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask
  task automatic fail(input string n);
    n_chk++;
    $display("FAIL %s: got timeout expected event", n);
  endtask
  // H.264 chroma DC: 2x2 Hadamard, then (f*LevelScale << qp/6) >> 5, wrapped to 15 bits
  function automatic grp_t model(input logic comp, input co_t c[4], input int qp);
    int ls[6] = '{160, 176, 208, 224, 256, 288};
    grp_t g;
    g.comp = comp;
    for (int k = 0; k < 4; k++) begin
      longint f = 0, x;
      for (int a = 0; a < 2; a++)
        for (int b = 0; b < 2; b++)
          f += ((((k >> 1) & a) ^ (k & 1 & b)) != 0 ? -1 : 1) * longint'(c[2*a+b]);
      x = (f * ls[qp % 6]) <<< (qp / 6);
      x = x >>> 5;
      g.d[k] = x[14:0];
    end
    return g;
  endfunction
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) dc_ready_i = 1;
    else if (rdy_mode == 1) dc_ready_i = 1'($urandom_range(0, 1));
    else begin
      hold = dc_valid_o ? hold + 1 : 0;
      dc_ready_i = hold > 10;
    end
  end
  logic pv = 0, pr = 0, exp_done = 0;
  logic [60:0] pvals = 0, cur;
  grp_t e;
  always @(negedge clk) begin
    if (rst) begin
      pv = 0;
      exp_done = 0;
    end else begin
      cur = {dc_comp_o, dc11_o, dc10_o, dc01_o, dc00_o};
      if (dc_valid_o) chk("ready_low_in_out", coeff_ready_o, 0);
      if (pv && !pr) begin
        chk("valid_held", dc_valid_o, 1);
        chk("data_held", cur, pvals);
      end
      if (exp_done || done_o) chk("done_pulse", done_o, exp_done);
      exp_done = 0;
      if (dc_valid_o && dc_ready_i) begin
        if (sb.size() == 0) chk("unexpected_group", 1, 0);
        else begin
          e = sb.pop_front();
          chk(dc_comp_o ? "dc_group_cr" : "dc_group_cb", cur, e);
        end
        exp_done = dc_comp_o;
      end
      pv = dc_valid_o;
      pr = dc_ready_i;
      pvals = cur;
    end
  end
  task automatic zero_chk(input string n);
    chk(n, {coeff_ready_o, dc_valid_o, dc_comp_o, dc00_o, dc01_o, dc10_o, dc11_o, busy_o, done_o}, 0);
  endtask
  task automatic send(input co_t c, input int gap);
    int g = gap < 0 ? int'($urandom_range(0, 3)) : gap;
    repeat (g) begin @(posedge clk); #1; end
    coeff_valid_i = 1;
    coeff_i = c;
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (coeff_ready_o) break;
      if (n > 300) begin fail("accept_timeout"); break; end
    end
    @(posedge clk); #1;
    coeff_valid_i = 0;
    coeff_i = 15'($urandom);
  endtask
  task automatic latency_chk();
    @(negedge clk);
    chk("calc_not_valid", dc_valid_o, 0);
    @(negedge clk);
    chk("valid_latency", dc_valid_o, 1);
    @(posedge clk); #1;
  endtask
  task automatic run_mb(input int qpb, input int qpr, input co_t cb[4], input co_t cr[4],
                        input int gap, input bit spurious, input bit abort);
    sb.push_back(model(0, cb, qpb));
    sb.push_back(model(1, cr, qpr));
    qp_cb_i = 6'(qpb);
    qp_cr_i = 6'(qpr);
    start_i = 1;
    @(posedge clk); #1;
    start_i = 0;
    chk("busy_after_start", busy_o, 1);
    for (int k = 0; k < 4; k++) begin
      if (spurious && k == 2) begin
        qp_cb_i = 6'(qpb ^ 5);
        qp_cr_i = 6'(qpr ^ 9);
        start_i = 1;
        @(posedge clk); #1;
        start_i = 0;
      end
      send(cb[k], gap);
    end
    latency_chk();
    for (int k = 0; k < 4; k++) begin
      if (abort && k == 2) begin
        rst = 1;
        #1;
        zero_chk("reset_mid_cr");
        sb.delete();
        @(posedge clk); #1;
        rst = 0;
        return;
      end
      send(cr[k], gap);
    end
    latency_chk();
    for (int n = 0; ; n++) begin
      @(negedge clk);
      if (done_o) break;
      if (n > 300) begin fail("done_timeout"); break; end
    end
  endtask
  co_t a[4], b[4];
  initial begin
    coeff_valid_i = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      zero_chk("idle_after_reset");
    end
    @(posedge clk); #1;
    coeff_valid_i = 0;
    rdy_mode = 0;
    a = '{1, 0, 0, 0}; b = '{0, 0, 0, 0};
    run_mb(0, 0, a, b, 0, 0, 0);
    a = '{1, 0, 0, 0}; b = '{-1, 0, 0, 0};
    run_mb(6, 12, a, b, 0, 0, 0);
    rdy_mode = 2;
    for (int k = 0; k < 4; k++) begin a[k] = co_t'($urandom_range(0, 400)) - 200; b[k] = co_t'($urandom); end
    run_mb(29, 51, a, b, 0, 0, 0);
    rdy_mode = 0;
    a = '{7, -3, 2, 5}; b = '{-8, 4, 0, 1};
    run_mb(20, 33, a, b, 2, 1, 0);
    a = '{3, 3, 3, 3}; b = '{9, 9, 9, 9};
    run_mb(10, 11, a, b, 0, 0, 1);
    @(negedge clk);
    zero_chk("idle_after_abort");
    a = '{-2, 6, 1, -1}; b = '{4, -4, 4, -4};
    run_mb(17, 40, a, b, 0, 0, 0);
    rdy_mode = 1;
    for (int m = 0; m < 20; m++) begin
      for (int k = 0; k < 4; k++) begin
        a[k] = (m % 3 == 0) ? co_t'($urandom) : co_t'($urandom_range(0, 512)) - 256;
        b[k] = (m % 3 == 1) ? co_t'($urandom) : co_t'($urandom_range(0, 512)) - 256;
      end
      run_mb(int'($urandom_range(0, 51)), int'($urandom_range(0, 51)), a, b, -1, m % 5 == 0, 0);
    end
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("idle_at_end", busy_o, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
